// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM/WB/ID bus bundle for the memory-access stage
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 146,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_ID_WD = 104
) ();
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

    // upstream side: drives the EX bus and SRAM read word, observes outputs
    modport master (
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_id_bus
    );

    // memory stage side
    modport slave (
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access pipeline stage with load alignment
module mem_stage #(
    parameter int EX_TO_MEM_WD = 146,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_ID_WD = 104,
    parameter int STALL_WD     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_WD-1:0] stall,
    mem_stage_if.slave          bus
);
    logic [EX_TO_MEM_WD-1:0] bus_r;
    logic                    first_r;
    logic                    hold_vld;
    logic [31:0]             hold_data;

    // only the EX and MEM stall bits matter here
    logic stall_ex;
    logic stall_mem;
    logic unused_stall;
    assign stall_ex     = stall[3];
    assign stall_mem    = stall[4];
    assign unused_stall = ^{stall[STALL_WD-1:5], stall[2:0]};

    logic bubble;
    logic advance;
    assign bubble  = stall_ex && !stall_mem;
    assign advance = !stall_ex;

    // EX->MEM pipeline register: reset, bubble, advance or hold
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus_r <= '0;
        end else if (advance) begin
            bus_r <= bus.ex_to_mem_bus;
        end
    end

    // SRAM word is only valid in the first MEM cycle; latch it if MEM stalls then
    always_ff @(posedge clk) begin
        if (rst) begin
            first_r   <= 1'b0;
            hold_vld  <= 1'b0;
            hold_data <= 32'h0;
        end else if (bubble) begin
            first_r  <= 1'b0;
            hold_vld <= 1'b0;
        end else if (advance) begin
            first_r  <= 1'b1;
            hold_vld <= 1'b0;
        end else begin
            first_r <= 1'b0;
            if (first_r && stall_mem) begin
                hold_data <= bus.data_sram_rdata;
                hold_vld  <= 1'b1;
            end
        end
    end

    logic [3:0]  readen;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign {readen, hi_we, lo_we, hi, lo, pc, ram_en, ram_wen,
            sel_rf_res, rf_we, rf_waddr, ex_result} = bus_r;

    logic [31:0] rd;
    assign rd = hold_vld ? hold_data : bus.data_sram_rdata;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;

    // pick the addressed byte/halfword and extend according to the load type
    always_comb begin
        byte_sel    = rd[7:0];
        half_sel    = ex_result[1] ? rd[31:16] : rd[15:0];
        load_result = rd;
        case (ex_result[1:0])
            2'd0: byte_sel = rd[7:0];
            2'd1: byte_sel = rd[15:8];
            2'd2: byte_sel = rd[23:16];
            2'd3: byte_sel = rd[31:24];
            default: byte_sel = rd[7:0];
        endcase
        case (readen)
            4'b1111: load_result = rd;
            4'b0001: load_result = {{24{byte_sel[7]}}, byte_sel};
            4'b0010: load_result = {24'h0, byte_sel};
            4'b0011: load_result = {{16{half_sel[15]}}, half_sel};
            4'b0100: load_result = {16'h0, half_sel};
            default: load_result = rd;
        endcase
    end

    logic [31:0] rf_wdata;
    assign rf_wdata = (sel_rf_res && ram_en && !(|ram_wen)) ? load_result : ex_result;

    logic [MEM_TO_WB_WD-1:0] wb_bus;
    logic [MEM_TO_ID_WD-1:0] id_bus;
    assign wb_bus = {hi_we, lo_we, hi, lo, pc, rf_we, rf_waddr, rf_wdata};
    assign id_bus = {rf_we, rf_waddr, rf_wdata, hi_we, lo_we, hi, lo};

    assign bus.mem_to_wb_bus = wb_bus;
    assign bus.mem_to_id_bus = id_bus;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    mem_stage_if bif ();

    mem_stage dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .bus   (bif)
    );

    typedef struct {
        logic [3:0]  readen;
        logic [31:0] exr;
        logic [31:0] rdata;
        logic        ram_en;
        logic [3:0]  wen;
        logic        sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[11];

    // reference state: instruction in MEM, whether it just arrived, captured word
    logic [145:0] m_bus   = '0;
    bit           m_fresh = 0;
    logic [31:0]  m_cap[$];

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [145:0] mk_ex(input logic [3:0] readen, input logic hi_we, input logic lo_we,
                                           input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] pc,
                                           input logic ram_en, input logic [3:0] ram_wen, input logic sel,
                                           input logic rf_we, input logic [4:0] waddr, input logic [31:0] exr);
        return {readen, hi_we, lo_we, hi, lo, pc, ram_en, ram_wen, sel, rf_we, waddr, exr};
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] readen, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        case (readen)
            4'b0001: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            4'b0010: return b;
            4'b0011: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4'b0100: return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [135:0] exp_wb(input logic [145:0] x, input logic [31:0] rd);
        logic [31:0] wd;
        wd = (x[38] && x[43] && x[42:39] == 4'b0) ? ref_load(x[145:142], x[1:0], rd) : x[31:0];
        return {x[141:44], x[37:32], wd};
    endfunction

    function automatic logic [103:0] exp_id(input logic [135:0] wb);
        return {wb[37:0], wb[135:70]};
    endfunction

    task automatic model_edge();
        if (rst || (stall[3] && !stall[4])) begin
            m_bus = '0;
            m_fresh = 0;
            m_cap.delete();
        end else if (!stall[3]) begin
            m_bus = bif.ex_to_mem_bus;
            m_fresh = 1;
            m_cap.delete();
        end else begin
            if (m_fresh && m_cap.size() == 0) m_cap.push_back(bif.data_sram_rdata);
            m_fresh = 0;
        end
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        logic [135:0] e;
        #1;
        e = exp_wb(m_bus, (m_cap.size() != 0) ? m_cap[0] : bif.data_sram_rdata);
        check({name, "_wb"}, bif.mem_to_wb_bus, e);
        check({name, "_id"}, {32'h0, bif.mem_to_id_bus}, {32'h0, exp_id(e)});
    endtask

    function automatic logic [145:0] rand_ex();
        logic [3:0] codes[8];
        codes = '{4'b1111, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0000, 4'b0101, 4'b1010};
        return mk_ex(codes[$urandom_range(0, 7)], 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0,
                     ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), $urandom);
    endfunction

    initial begin
        vt[0]  = '{4'b0001, 32'h1000_0002, 32'h80F1_7F22, 1'b1, 4'b0, 1'b1, 32'hFFFF_FFF1};
        vt[1]  = '{4'b0010, 32'h1000_0003, 32'h80F1_7F22, 1'b1, 4'b0, 1'b1, 32'h0000_0080};
        vt[2]  = '{4'b0001, 32'h1000_0000, 32'h80F1_7F22, 1'b1, 4'b0, 1'b1, 32'h0000_0022};
        vt[3]  = '{4'b0011, 32'h2000_0002, 32'h8001_F00F, 1'b1, 4'b0, 1'b1, 32'hFFFF_8001};
        vt[4]  = '{4'b0100, 32'h2000_0000, 32'h8001_F00F, 1'b1, 4'b0, 1'b1, 32'h0000_F00F};
        vt[5]  = '{4'b1111, 32'h2000_0100, 32'h8001_F00F, 1'b1, 4'b0, 1'b1, 32'h8001_F00F};
        vt[6]  = '{4'b0011, 32'h2000_0003, 32'h8001_F00F, 1'b1, 4'b0, 1'b1, 32'hFFFF_8001};
        vt[7]  = '{4'b0010, 32'h1000_0001, 32'h80F1_7F22, 1'b1, 4'b0, 1'b1, 32'h0000_007F};
        vt[8]  = '{4'b0101, 32'h0000_1233, 32'h80F1_7F22, 1'b1, 4'b0001, 1'b1, 32'h0000_1233};
        vt[9]  = '{4'b0000, 32'h0000_0064, 32'hABCD_0123, 1'b0, 4'b0, 1'b0, 32'h0000_0064};
        vt[10] = '{4'b1000, 32'h3000_0000, 32'h1122_3344, 1'b1, 4'b0, 1'b1, 32'h1122_3344};

        // reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stall = 6'($urandom);
            bif.ex_to_mem_bus = rand_ex();
            bif.data_sram_rdata = $urandom;
            clk_edge();
        end
        #1;
        check("reset_wb", bif.mem_to_wb_bus, 136'h0);
        check("reset_id", {32'h0, bif.mem_to_id_bus}, 136'h0);
        rst = 1'b0;

        // load alignment vectors
        for (int i = 0; i < 11; i++) begin
            stall = 6'b0;
            bif.ex_to_mem_bus = mk_ex(vt[i].readen, 1'b0, 1'b0, 32'h0, 32'h0, 32'h400 + 32'(i * 4),
                                      vt[i].ram_en, vt[i].wen, vt[i].sel, 1'b1, 5'd2, vt[i].exr);
            clk_edge();
            bif.data_sram_rdata = vt[i].rdata;
            #1;
            check($sformatf("vec%0d_wdata", i), {104'h0, bif.mem_to_wb_bus[31:0]}, {104'h0, vt[i].exp});
        end

        // stalled load keeps the first-cycle word
        stall = 6'b0;
        bif.ex_to_mem_bus = mk_ex(4'b1111, 1'b0, 1'b0, 32'h0, 32'h0, 32'h500, 1'b1, 4'b0, 1'b1, 1'b1, 5'd9, 32'h200);
        clk_edge();
        bif.data_sram_rdata = 32'h1234_5678;
        stall = 6'b011111;
        #1;
        check("stall_first", {104'h0, bif.mem_to_wb_bus[31:0]}, {104'h0, 32'h1234_5678});
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            bif.data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            check($sformatf("stall_hold%0d", i), {104'h0, bif.mem_to_wb_bus[31:0]}, {104'h0, 32'h1234_5678});
        end
        stall = 6'b0;
        bif.ex_to_mem_bus = mk_ex(4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h504, 1'b0, 4'b0, 1'b0, 1'b1, 5'd3, 32'h55);
        #1;
        check("stall_release", {104'h0, bif.mem_to_wb_bus[31:0]}, {104'h0, 32'h1234_5678});
        clk_edge();

        // bubble insertion then resume
        stall = 6'b0;
        bif.ex_to_mem_bus = mk_ex(4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h600, 1'b0, 4'b0, 1'b0, 1'b1, 5'd4, 32'h77);
        clk_edge();
        #1;
        check("pre_bubble_rf_we", {135'h0, bif.mem_to_wb_bus[37]}, 136'h1);
        stall = 6'b001111;
        bif.ex_to_mem_bus = mk_ex(4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h604, 1'b0, 4'b0, 1'b0, 1'b1, 5'd5, 32'h88);
        clk_edge();
        #1;
        check("bubble_wb", bif.mem_to_wb_bus, 136'h0);
        check("bubble_id", {32'h0, bif.mem_to_id_bus}, 136'h0);
        stall = 6'b0;
        clk_edge();
        #1;
        check("resume_wb", bif.mem_to_wb_bus,
              {2'b0, 32'h0, 32'h0, 32'h604, 1'b1, 5'd5, 32'h88});

        // ALU result and HI/LO write-back
        bif.ex_to_mem_bus = mk_ex(4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h700, 1'b0, 4'b0, 1'b0, 1'b1, 5'd3, 32'h64);
        clk_edge();
        #1;
        check("alu_wdata", {104'h0, bif.mem_to_wb_bus[31:0]}, {104'h0, 32'h64});
        bif.ex_to_mem_bus = mk_ex(4'b0, 1'b1, 1'b1, 32'h1, 32'hFFFF_FFFE, 32'h704, 1'b0, 4'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        clk_edge();
        #1;
        check("mult_wb_hilo", {70'h0, bif.mem_to_wb_bus[135:70]}, {70'h0, 2'b11, 32'h1, 32'hFFFF_FFFE});
        check("mult_id_hilo", {70'h0, bif.mem_to_id_bus[65:0]}, {70'h0, 2'b11, 32'h1, 32'hFFFF_FFFE});

        // reset while a captured load is held
        stall = 6'b0;
        bif.ex_to_mem_bus = mk_ex(4'b1111, 1'b0, 1'b0, 32'h0, 32'h0, 32'h800, 1'b1, 4'b0, 1'b1, 1'b1, 5'd7, 32'h300);
        clk_edge();
        bif.data_sram_rdata = 32'hCAFE_F00D;
        stall = 6'b011111;
        clk_edge();
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        #1;
        check("rst_stall_wb", bif.mem_to_wb_bus, 136'h0);
        check("rst_stall_id", {32'h0, bif.mem_to_id_bus}, 136'h0);
        bif.data_sram_rdata = 32'h9999_9999;
        clk_edge();
        #1;
        check("rst_stall_after", bif.mem_to_wb_bus, 136'h0);

        // randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0, 1: stall = 6'b0;
                2: stall = 6'b011111;
                default: stall = 6'b001111;
            endcase
            bif.ex_to_mem_bus = rand_ex();
            clk_edge();
            bif.data_sram_rdata = $urandom;
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
